vessel_renderer: RTL

Parametrised, clocked sprite renderer for the 96x64 OLED that draws one liquid vessel with `LAYERS` stacked colour bands, a cap and an animated fill level. It sits between the pixel-index/coordinate logic and the OLED pixel mux, once per vessel on screen. It is the generalised successor of the fixed four-band boiler sprite and adds configurable layer count, band height and body width. It also adds a registered output, fill/drain animation and a blinking cap when selected.

---
 rtl/vessel_renderer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vessel_renderer.sv
// Clocked sprite renderer for one liquid vessel on the 96x64 OLED: stacked colour
// bands, a cap that blinks while selected, and a fill level animated one row per frame.
module vessel_renderer #(
  parameter int LAYERS       = 4,
  parameter int LAYER_ROWS   = 4,
  parameter int WIDTH        = 12,
  parameter int CW           = 3,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_tick,
  input  logic [6:0]                   x,
  input  logic [5:0]                   y,
  input  logic [6:0]                   left_x,
  input  logic [5:0]                   top_y,
  input  logic [15:0]                  background,
  input  logic                         selected,
  input  logic [LAYERS*CW-1:0]         colours,
  input  logic [$clog2(LAYERS+1)-1:0]  level,
  output logic [15:0]                  oled_data
);

  localparam int ROWS   = LAYERS * LAYER_ROWS;
  localparam int H      = 3 + ROWS + 1;
  localparam int DISP_W = $clog2(ROWS + 1);
  localparam int SHIFT  = $clog2(LAYER_ROWS);
  localparam int CNT_W  = $clog2(BLINK_FRAMES + 1);

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] BROWN = 16'h60E0;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} fill_state_e;

  function automatic logic [15:0] palette(input logic [CW-1:0] code);
    case (int'(code))
      0:       palette = 16'hFFFF;
      1:       palette = 16'hCB92;
      2:       palette = 16'hA776;
      3:       palette = 16'hED6C;
      4:       palette = 16'h0016;
      5:       palette = 16'h06B8;
      6:       palette = 16'hA534;
      default: palette = RED;
    endcase
  endfunction

  logic [DISP_W-1:0] disp_rows, disp_next, tgt;
  logic [CNT_W-1:0]  blink_cnt;
  logic              blink_phase;
  fill_state_e       state;

  // The direction is derived from the live target every cycle, so a level change
  // landing on the same cycle as a tick already steers that step.
  always_comb begin
    int lvl;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    lvl       = int'(level);
    tgt       = DISP_W'(((lvl > LAYERS) ? LAYERS : lvl) * LAYER_ROWS);
    state     = IDLE;
    disp_next = disp_rows;
    if (disp_rows < tgt)      state = FILL;
    else if (disp_rows > tgt) state = DRAIN;
    if (frame_tick) begin
      if (state == FILL)       disp_next = disp_rows + 1'b1;
      else if (state == DRAIN) disp_next = disp_rows - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_rows   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      disp_rows <= disp_next;
      if (!selected) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (frame_tick) begin
        if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Relative coordinates are 8 bits wide so a pixel left of/above the box cannot alias inside it.
  logic [7:0]    rx, ry, b, layer;
  logic [CW-1:0] code;
  logic          outside;
  logic [15:0]   cap_colour, pix;

  always_comb begin
    rx         = {1'b0, x} - {1'b0, left_x};
    ry         = {2'b00, y} - {2'b00, top_y};
    b          = 8'(H - 2) - ry;
    layer      = b >> SHIFT;
    outside    = (x < left_x) || (y < top_y) || (rx >= 8'(WIDTH)) || (ry >= 8'(H));
    cap_colour = (selected && blink_phase) ? RED : BROWN;
    code       = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (layer == 8'(i)) code = colours[i*CW +: CW];
    end
    pix = background;
    if (!outside) begin
      if (ry < 8'd3) begin
        if (rx >= 8'd1 && rx <= 8'(WIDTH - 2)) pix = cap_colour;
      end else if (ry == 8'(H - 1)) begin
        pix = BLACK;
      end else if (rx == 8'd0 || rx == 8'(WIDTH - 1)) begin
        pix = BLACK;
      end else if (b < 8'(disp_rows)) begin
        pix = palette(code);
      end else begin
        pix = WHITE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oled_data <= '0;
    else        oled_data <= pix;
  end

endmodule
